// File: rtl/fsm_counter_param.sv
`default_nettype none
// ============================================================================
// fsm_counter_param
//   Programmable cycle counter FSM: run/pause/done with auto-reload and abort.
//   Rev 1.0
// ============================================================================
module fsm_counter_param #(
    parameter int CNT_WIDTH  = 16,
    parameter int LOOP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  is_run,
    input  logic [CNT_WIDTH-1:0]  i_num_cnt,
    input  logic                  i_reload,
    input  logic                  i_pause,
    input  logic                  i_abort,
    output logic                  o_idle,
    output logic                  o_running,
    output logic                  o_paused,
    output logic                  o_done,
    output logic [CNT_WIDTH-1:0]  o_cnt,
    output logic [LOOP_WIDTH-1:0] o_loops
);

    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LOOP_WIDTH-1:0] LOOP_ONE = {{(LOOP_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    target_q, target_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    reload_q, reload_d;
    logic [LOOP_WIDTH-1:0]   loops_q, loops_d;
    logic                    last_cnt;

    assign last_cnt = (cnt_q == (target_q - CNT_ONE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            cnt_q    <= '0;
            reload_q <= 1'b0;
            loops_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            loops_q  <= loops_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        loops_d  = loops_q;
        case (state_q)
            ST_IDLE: begin
                if (is_run) begin
                    target_d = i_num_cnt;
                    reload_d = i_reload;
                    cnt_d    = '0;
                    loops_d  = '0;
                    state_d  = (i_num_cnt != '0) ? ST_RUN : ST_DONE;
                end
            end
            // The RUN cycle that saw pause already consumed its count slot, so
            // leaving PAUSE advances the count (or finishes the pass) directly.
            ST_RUN, ST_PAUSE: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (i_pause) begin
                    state_d = ST_PAUSE;
                end else if (last_cnt) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                loops_d = loops_q + LOOP_ONE;
                if (i_abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (reload_q) begin
                    cnt_d   = '0;
                    state_d = (target_q == '0) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_idle    = (state_q == ST_IDLE);
    assign o_running = (state_q == ST_RUN);
    assign o_paused  = (state_q == ST_PAUSE);
    assign o_done    = (state_q == ST_DONE);
    assign o_cnt     = cnt_q;
    assign o_loops   = loops_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_counter_param.sv
`default_nettype none
// ============================================================================
// tb_fsm_counter_param
//   Scoreboard bench: expected done events queued at start, matched on o_done.
//   Rev 1.0
// ============================================================================
module tb_fsm_counter_param;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        is_run, i_reload, i_pause, i_abort;
    logic [15:0] i_num_cnt;
    logic        o_idle, o_running, o_paused, o_done;
    logic [15:0] o_cnt;
    logic [7:0]  o_loops;

    logic        is_run2;
    logic [3:0]  i_num_cnt2;
    logic        o_idle2, o_running2, o_paused2, o_done2;
    logic [3:0]  o_cnt2;
    logic [7:0]  o_loops2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int cyc;
        int loops;
        int cnt;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fsm_counter_param #(.CNT_WIDTH(16), .LOOP_WIDTH(8)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .is_run    (is_run),
        .i_num_cnt (i_num_cnt),
        .i_reload  (i_reload),
        .i_pause   (i_pause),
        .i_abort   (i_abort),
        .o_idle    (o_idle),
        .o_running (o_running),
        .o_paused  (o_paused),
        .o_done    (o_done),
        .o_cnt     (o_cnt),
        .o_loops   (o_loops)
    );

    fsm_counter_param #(.CNT_WIDTH(4), .LOOP_WIDTH(8)) u_dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .is_run    (is_run2),
        .i_num_cnt (i_num_cnt2),
        .i_reload  (1'b0),
        .i_pause   (1'b0),
        .i_abort   (1'b0),
        .o_idle    (o_idle2),
        .o_running (o_running2),
        .o_paused  (o_paused2),
        .o_done    (o_done2),
        .o_cnt     (o_cnt2),
        .o_loops   (o_loops2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input int c, input int l, input int n);
        exp_t e;
        e.cyc   = c;
        e.loops = l;
        e.cnt   = n;
        sb_q.push_back(e);
    endtask

    // Caller sits at a negedge; returns at the negedge after the accepting edge.
    task automatic kick(input int n, input logic rl);
        i_num_cnt = 16'(n);
        i_reload  = rl;
        is_run    = 1'b1;
        @(negedge clk);
        is_run    = 1'b0;
    endtask

    always @(negedge clk) begin
        if (o_done) begin
            if (sb_q.size() == 0) begin
                check_val("sb_spurious_done", {31'd0, o_done}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("sb_done_cyc", cyc, e.cyc);
                check_val("sb_done_loops", {24'd0, o_loops}, e.loops);
                check_val("sb_done_cnt", {16'd0, o_cnt}, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int runs, peak, dones;
        reset_n    = 1'b0;
        is_run     = 1'b0;
        i_num_cnt  = '0;
        i_reload   = 1'b0;
        i_pause    = 1'b0;
        i_abort    = 1'b0;
        is_run2    = 1'b0;
        i_num_cnt2 = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("rst_idle", {31'd0, o_idle}, 1);
        check_val("rst_running", {31'd0, o_running}, 0);
        check_val("rst_paused", {31'd0, o_paused}, 0);
        check_val("rst_done", {31'd0, o_done}, 0);
        check_val("rst_cnt", {16'd0, o_cnt}, 0);
        check_val("rst_loops", {24'd0, o_loops}, 0);

        // Single pass of 100 cycles
        a = cyc + 1;
        push_exp(a + 100, 0, 99);
        kick(100, 1'b0);
        for (int i = 0; i < 100; i++) begin
            check_val("t1_running", {31'd0, o_running}, 1);
            check_val("t1_cnt", {16'd0, o_cnt}, i);
            @(negedge clk);
        end
        @(negedge clk);
        check_val("t1_idle", {31'd0, o_idle}, 1);
        check_val("t1_loops", {24'd0, o_loops}, 1);
        check_val("t1_cnt_kept", {16'd0, o_cnt}, 99);

        // Auto-reload, three passes, abort in the fourth
        @(negedge clk);
        a = cyc + 1;
        push_exp(a + 5, 0, 4);
        push_exp(a + 11, 1, 4);
        push_exp(a + 17, 2, 4);
        kick(5, 1'b1);
        while (cyc < a + 20) @(negedge clk);
        check_val("t2_cnt_pre_abort", {16'd0, o_cnt}, 2);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check_val("t2_idle", {31'd0, o_idle}, 1);
        check_val("t2_cnt", {16'd0, o_cnt}, 0);
        check_val("t2_loops", {24'd0, o_loops}, 3);

        // Pause for 7 cycles at count 10
        @(negedge clk);
        a = cyc + 1;
        push_exp(a + 27, 0, 19);
        kick(20, 1'b0);
        for (int k = 0; k < 40 && o_cnt != 16'd10; k++) @(negedge clk);
        check_val("t3_reach10", {16'd0, o_cnt}, 10);
        i_pause = 1'b1;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            check_val("t3_paused", {31'd0, o_paused}, 1);
            check_val("t3_frozen", {16'd0, o_cnt}, 10);
        end
        i_pause = 1'b0;
        @(negedge clk);
        check_val("t3_resume_cnt", {16'd0, o_cnt}, 11);
        while (cyc < a + 29) @(negedge clk);
        check_val("t3_idle", {31'd0, o_idle}, 1);

        // Zero-length pass, then zero-length with reload until abort
        a = cyc + 1;
        push_exp(a, 0, 0);
        kick(0, 1'b0);
        @(negedge clk);
        check_val("t4_idle", {31'd0, o_idle}, 1);
        check_val("t4_loops", {24'd0, o_loops}, 1);
        a = cyc + 1;
        for (int j = 0; j < 4; j++) push_exp(a + j, j, 0);
        kick(0, 1'b1);
        repeat (3) @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check_val("t4r_idle", {31'd0, o_idle}, 1);
        check_val("t4r_loops", {24'd0, o_loops}, 4);

        // Ignored is_run mid-run, then async reset mid-pass at count 37
        @(negedge clk);
        a = cyc + 1;
        push_exp(a + 40, 0, 39);
        kick(40, 1'b1);
        while (cyc < a + 5) @(negedge clk);
        i_num_cnt = 16'd3;
        i_reload  = 1'b0;
        is_run    = 1'b1;
        @(negedge clk);
        is_run    = 1'b0;
        check_val("t5_ignored_cnt", {16'd0, o_cnt}, 6);
        check_val("t5_ignored_run", {31'd0, o_running}, 1);
        while (cyc < a + 78) @(negedge clk);
        check_val("t5_cnt37", {16'd0, o_cnt}, 37);
        check_val("t5_loops_pre", {24'd0, o_loops}, 1);
        #2 reset_n = 1'b0;
        #1;
        check_val("t5_rst_idle", {31'd0, o_idle}, 1);
        check_val("t5_rst_cnt", {16'd0, o_cnt}, 0);
        check_val("t5_rst_loops", {24'd0, o_loops}, 0);
        check_val("t5_rst_done", {31'd0, o_done}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check_val("t5_post_idle", {31'd0, o_idle}, 1);

        // 4-bit instance at its maximum run length
        i_num_cnt2 = 4'd15;
        is_run2    = 1'b1;
        runs  = 0;
        peak  = 0;
        dones = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            is_run2 = 1'b0;
            if (o_running2) runs++;
            if (int'(o_cnt2) > peak) peak = int'(o_cnt2);
            if (o_done2) dones++;
        end
        check_val("t6_runs", runs, 15);
        check_val("t6_peak", peak, 14);
        check_val("t6_dones", dones, 1);
        check_val("t6_idle", {31'd0, o_idle2}, 1);
        check_val("t6_loops", {24'd0, o_loops2}, 1);

        check_val("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
